// File: rtl/assign_trail.sv
// -----------------------------------------------------------------------------
// assign_trail
//
// Assignment trail for a hardware DPLL SAT engine.
//
// Assignments made by BCP or by the decision logic are pushed onto a trail
// stack. Each entry holds {var, val, dec}. The module also keeps the current
// assignment and free vectors that feed BCP.
//
// A conflict pulse in IDLE starts a backtrack. Implied entries are popped
// one per cycle. The newest decision is then flipped in place and becomes an
// implication. If the trail empties before any decision is found, the block
// locks in UNSAT until reset.
//
// Parameters
//   VAR_NUM : number of variables
//   VAR_W   : variable index width (clog2 of VAR_NUM)
//   DEPTH   : trail entries; the stack pointer and level are clog2(DEPTH)+1 bits
//
// Ports
//   clk, rst            : clock; asynchronous active-high reset
//   push_valid/var/val/dec, push_ready : assignment push handshake
//   conflict            : one-cycle pulse requesting a backtrack
//   assignment, free    : current values / unassigned mask, fed to BCP
//   level               : number of decision entries on the trail
//   busy                : high while popping or flipping
//   bt_done, flip_var, flip_val : one-cycle report of the flipped decision
//   unsat               : sticky; no decision was left to flip
//   full                : trail stack is full
//   err                 : sticky; a push was dropped
//
// Build option
//   TRAIL_DUP_CHECK_EN  : when defined, a push to an already-assigned variable
//                         is dropped and sets err.
// -----------------------------------------------------------------------------
module assign_trail #(
    parameter int VAR_NUM = 4,
    parameter int VAR_W   = 2,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    input  logic [VAR_W-1:0]           push_var,
    input  logic                       push_val,
    input  logic                       push_dec,
    output logic                       push_ready,
    input  logic                       conflict,
    output logic [VAR_NUM-1:0]         assignment,
    output logic [VAR_NUM-1:0]         free,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy,
    output logic                       bt_done,
    output logic [VAR_W-1:0]           flip_var,
    output logic                       flip_val,
    output logic                       unsat,
    output logic                       full,
    output logic                       err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, BT, DONE, UNSAT} state_t;

    state_t state, state_next;

    // Trail storage; contents are only meaningful below sp, so no reset.
    logic [VAR_W-1:0] trail_var [DEPTH];
    logic             trail_val [DEPTH];
    logic             trail_dec [DEPTH];

    logic [PTR_W-1:0] sp;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic [VAR_W-1:0] top_var;
    logic             top_val;
    logic             top_dec;
    logic             push_dup;
    logic             push_take;
    logic             push_drop;
    logic             bt_pop;
    logic             bt_flip;

    assign wr_idx  = sp[IDX_W-1:0];
    assign top_idx = IDX_W'(sp - PTR_W'(1));
    assign top_var = trail_var[top_idx];
    assign top_val = trail_val[top_idx];
    assign top_dec = trail_dec[top_idx];

    assign full       = (sp == PTR_W'(DEPTH));
    // Conflict takes priority so BCP never races a push against a backtrack.
    assign push_ready = (state == IDLE) && !full && !conflict;

`ifdef TRAIL_DUP_CHECK_EN
    assign push_dup = !free[push_var];
`else
    assign push_dup = 1'b0;
`endif

    assign push_take = push_valid && push_ready && !push_dup;
    assign push_drop = push_valid && (state == IDLE) &&
                       (full || (push_ready && push_dup));

    assign bt_pop  = (state == BT) && (sp != '0) && !top_dec;
    assign bt_flip = (state == BT) && (sp != '0) &&  top_dec;

    assign busy    = (state == BT);
    assign bt_done = (state == DONE);
    assign unsat   = (state == UNSAT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (conflict) state_next = BT;
            BT: begin
                if (sp == '0)   state_next = UNSAT;
                else if (top_dec) state_next = DONE;
            end
            DONE:  state_next = IDLE;
            UNSAT: state_next = UNSAT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push_take) begin
            trail_var[wr_idx] <= push_var;
            trail_val[wr_idx] <= push_val;
            trail_dec[wr_idx] <= push_dec;
        end else if (bt_flip) begin
            // A flipped decision stays in place as an implication so a later
            // backtrack pops it and continues to older decisions.
            trail_val[top_idx] <= ~top_val;
            trail_dec[top_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp         <= '0;
            level      <= '0;
            assignment <= '0;
            free       <= '1;
            flip_var   <= '0;
            flip_val   <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (push_drop) err <= 1'b1;
            if (push_take) begin
                sp                   <= sp + PTR_W'(1);
                assignment[push_var] <= push_val;
                free[push_var]       <= 1'b0;
                if (push_dec) level  <= level + PTR_W'(1);
            end else if (bt_pop) begin
                sp                  <= sp - PTR_W'(1);
                free[top_var]       <= 1'b1;
                assignment[top_var] <= 1'b0;
            end else if (bt_flip) begin
                assignment[top_var] <= ~top_val;
                level               <= level - PTR_W'(1);
                flip_var            <= top_var;
                flip_val            <= ~top_val;
            end
        end
    end

endmodule

// File: tb/tb_assign_trail.sv
module tb_assign_trail;

    localparam int VAR_NUM = 4;
    localparam int VAR_W   = 2;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               push_valid = 1'b0;
    logic [VAR_W-1:0]   push_var = '0;
    logic               push_val = 1'b0;
    logic               push_dec = 1'b0;
    logic               push_ready;
    logic               conflict = 1'b0;
    logic [VAR_NUM-1:0] assignment;
    logic [VAR_NUM-1:0] free;
    logic [PTR_W-1:0]   level;
    logic               busy;
    logic               bt_done;
    logic [VAR_W-1:0]   flip_var;
    logic               flip_val;
    logic               unsat;
    logic               full;
    logic               err;

    assign_trail #(.VAR_NUM(VAR_NUM), .VAR_W(VAR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_var(push_var), .push_val(push_val),
        .push_dec(push_dec), .push_ready(push_ready), .conflict(conflict),
        .assignment(assignment), .free(free), .level(level), .busy(busy),
        .bt_done(bt_done), .flip_var(flip_var), .flip_val(flip_val),
        .unsat(unsat), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the trail
    logic [VAR_W-1:0]   m_var [DEPTH];
    logic               m_val [DEPTH];
    logic               m_dec [DEPTH];
    int                 m_sp;
    int                 m_level;
    logic [VAR_NUM-1:0] m_asg;
    logic [VAR_NUM-1:0] m_free;
    bit                 m_err;
    bit                 m_unsat;

    typedef struct {
        bit               is_unsat;
        logic [VAR_W-1:0] v;
        logic             val;
        int               busy_cycles;
    } sb_t;
    sb_t sb[$];

    task automatic model_reset();
        m_sp = 0; m_level = 0; m_asg = '0; m_free = '1;
        m_err = 0; m_unsat = 0;
        sb.delete();
    endtask

    task automatic model_push(input logic [VAR_W-1:0] v, input logic val, input logic dec);
        if (m_unsat) return;
        if (m_sp == DEPTH) begin m_err = 1; return; end
`ifdef TRAIL_DUP_CHECK_EN
        if (!m_free[v]) begin m_err = 1; return; end
`endif
        m_var[m_sp] = v; m_val[m_sp] = val; m_dec[m_sp] = dec;
        m_sp++;
        m_asg[v] = val; m_free[v] = 1'b0;
        if (dec) m_level++;
    endtask

    task automatic model_conflict();
        sb_t e;
        int  k = 0;
        if (m_unsat) return;
        while (m_sp > 0 && !m_dec[m_sp-1]) begin
            m_sp--;
            m_free[m_var[m_sp]] = 1'b1;
            m_asg[m_var[m_sp]]  = 1'b0;
            k++;
        end
        e.busy_cycles = k + 1;
        if (m_sp == 0) begin
            e.is_unsat = 1; e.v = '0; e.val = 0;
            m_unsat = 1;
        end else begin
            m_val[m_sp-1] = ~m_val[m_sp-1];
            m_dec[m_sp-1] = 1'b0;
            m_asg[m_var[m_sp-1]] = m_val[m_sp-1];
            m_level--;
            e.is_unsat = 0; e.v = m_var[m_sp-1]; e.val = m_val[m_sp-1];
        end
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1; push_valid = 0; conflict = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic [VAR_W-1:0] v, input logic val, input logic dec);
        push_valid = 1; push_var = v; push_val = val; push_dec = dec;
        @(posedge clk); #1;
        push_valid = 0;
        model_push(v, val, dec);
    endtask

    // Conflict pulse, optionally with a competing push in the same cycle.
    task automatic pulse_conflict(input bit with_push);
        conflict = 1;
        if (with_push) begin
            push_valid = 1; push_var = 2'd0; push_val = 1; push_dec = 1;
        end
        @(posedge clk); #1;
        conflict = 0; push_valid = 0;
        model_conflict();
    endtask

    task automatic wait_bt(input string tag);
        sb_t e;
        int  n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bt_done || unsat) break;
            if (busy) n++;
        end
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_busy_cycles"}, n, e.busy_cycles);
        if (e.is_unsat) begin
            chk({tag, "_unsat"}, unsat, 1);
        end else begin
            chk({tag, "_bt_done"}, bt_done, 1);
            chk({tag, "_flip_var"}, flip_var, e.v);
            chk({tag, "_flip_val"}, flip_val, e.val);
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, "_assignment"}, assignment, m_asg);
        chk({tag, "_free"}, free, m_free);
        chk({tag, "_level"}, level, m_level);
        chk({tag, "_full"}, full, (m_sp == DEPTH));
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_unsat"}, unsat, m_unsat);
        chk({tag, "_push_ready"}, push_ready, !m_unsat && (m_sp != DEPTH));
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset values
        check_state("rst");
        chk("rst_bt_done", bt_done, 0);
        chk("rst_flip_var", flip_var, 0);
        chk("rst_flip_val", flip_val, 0);
        chk("rst_assignment_lit", assignment, 4'b0000);
        chk("rst_free_lit", free, 4'b1111);

        // Decision with two implications above it
        push(2'd3, 1, 1);
        push(2'd1, 0, 0);
        push(2'd2, 1, 0);
        check_state("three_push");
        pulse_conflict(0);
        wait_bt("bt1");
        check_state("bt1_after");
        chk("bt1_free_lit", free, 4'b0111);
        chk("bt1_level_lit", level, 0);

        // Flipped decision is an implication: next backtrack exhausts trail
        pulse_conflict(0);
        wait_bt("bt1_unsat");
        check_state("bt1_unsat_after");

        // Two decisions: second backtrack pops the flipped one and flips older
        do_reset();
        push(2'd0, 1, 1);
        push(2'd1, 1, 1);
        push(2'd2, 0, 0);
        pulse_conflict(0);
        wait_bt("bt2a");
        check_state("bt2a_after");
        pulse_conflict(0);
        wait_bt("bt2b");
        check_state("bt2b_after");

        // Only implied entries: pop then unsat, sticky
        do_reset();
        push(2'd0, 1, 0);
        pulse_conflict(0);
        wait_bt("imp_only");
        push(2'd1, 1, 1);
        pulse_conflict(0);
        repeat (3) @(posedge clk);
        check_state("unsat_sticky");

        // Fill the trail, then an extra push is dropped
        do_reset();
        push(2'd0, 1, 1);
        push(2'd1, 1, 0);
        push(2'd2, 0, 0);
        push(2'd3, 1, 0);
        push(2'd1, 0, 1);
        push(2'd2, 1, 0);
        push(2'd3, 0, 0);
        push(2'd0, 0, 0);
        check_state("fill");
        push(2'd2, 0, 1);
        check_state("overflow");
        pulse_conflict(0);
        wait_bt("bt_full");
        check_state("bt_full_after");

        // Conflict beats a same-cycle push
        do_reset();
        push(2'd2, 1, 1);
        pulse_conflict(1);
        wait_bt("race");
        check_state("race_after");

        // Reset in the middle of a backtrack takes effect immediately
        push(2'd1, 1, 1);
        push(2'd0, 1, 0);
        push(2'd3, 1, 0);
        pulse_conflict(0);
        @(negedge clk);
        chk("midbt_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("midbt_rst_busy", busy, 0);
        chk("midbt_rst_assignment", assignment, 4'b0000);
        chk("midbt_rst_free", free, 4'b1111);
        chk("midbt_rst_level", level, 0);
        chk("midbt_rst_flip", {flip_var, flip_val}, 0);
        chk("midbt_rst_flags", {bt_done, unsat, err, full}, 0);
        chk("midbt_rst_ready", push_ready, 1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        check_state("midbt_release");

        // Pushing the same variable twice
        do_reset();
        push(2'd2, 1, 1);
        push(2'd2, 0, 1);
        check_state("dup");
`ifdef TRAIL_DUP_CHECK_EN
        chk("dup_err_lit", err, 1);
        chk("dup_level_lit", level, 1);
`else
        chk("dup_err_lit", err, 0);
        chk("dup_level_lit", level, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
